alu_mult_seq: RTL
=================

ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

Interface
REQ-001 clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  request to multiply; sampled only in IDLE.
REQ-004 opA  in  16  multiplicand; sampled with start.
REQ-005 opB  in  16  multiplier; sampled with start.
REQ-006 sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 busy  out  1  high in ITER and DONE.
REQ-008 done  out  1  one-cycle pulse; product valid.
REQ-009 product  out  32  result; held until the next accepted start.
REQ-010 aluA, aluB  out  16 each  ALU operand drive.
REQ-011 aluOp  out  4  ALU opcode, always ALU_OP_ADD.
REQ-012 aluCin, aluInvA, aluInvB, aluSign  out  1 each  ALU controls, always 0.
REQ-013 aluOut  in  16  ALU sum.
REQ-014 aluOfl  in  1  with aluSign=0, the unsigned carry-out of the add.
REQ-015 aluZero, aluNeg  in  1 each  present for interface completeness; ignored.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ITER, DONE.
REQ-017 IDLE, start=1: latch |opA| into mcand and |opB| into mplr, with magnitudes taken only when sgn=1; latch neg = sgn & (opA[15]^opB[15]); clear acc_hi; clear cnt; go to ITER.
REQ-018 Magnitude of 0x8000 SHALL be 0x8000, treated as unsigned 16-bit.
REQ-019 ITER, every cycle: aluA=acc_hi; aluB = mplr[0] ? mcand : 0.
REQ-020 ITER, every cycle: {acc_hi, mplr} <= {aluOfl, aluOut, mplr[15:1]}, a 33-bit right shift; cnt increments.
REQ-021 ITER, when cnt=15: complete the final update; product <= neg ? two's-complement of {acc_hi, mplr} : {acc_hi, mplr}; go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-023 Latency: start sampled at edge 0; product valid and done high after edge 16; IDLE again after edge 17.
REQ-024 start while busy=1, including during DONE, SHALL be ignored with no effect.
REQ-025 start high in consecutive IDLE cycles SHALL launch back-to-back operations, with no dead cycle other than DONE.
REQ-026 In IDLE and DONE, aluA and aluB SHALL be 0; aluOp, aluCin, aluInvA, aluInvB and aluSign SHALL keep their constant values.
REQ-027 Operand inputs SHALL not be sampled outside the accepting IDLE edge.

Reset
REQ-028 rst low SHALL immediately force: state=IDLE, busy=0, done=0, product=0, cnt=0, acc_hi=0, aluA=aluB=0.
REQ-029 Reset mid-operation SHALL abandon the operation, with no done pulse and product=0.
REQ-030 The first start is accepted on the first rising edge after rst deasserts.

Structure
REQ-031 Package alu_pkg SHALL hold ALU_OP_ADD (4-bit), the FSM state encoding, and the N=16 width constant.
REQ-032 The block SHALL contain no ALU of its own; addition comes only through the alu* port pair.
REQ-033 The 32-bit result negation SHALL be local combinational logic.
REQ-034 One sub-module is natural, mult_fsm (state, cnt, busy/done), instantiated in alu_mult_seq.
REQ-035 The bench SHALL connect the alu* ports to the team's existing alu instance.

Verification
REQ-036 sgn=0, opA=3, opB=5 -> done after edge 16; product=0x0000000F.
REQ-037 sgn=0, opA=0xFFFF, opB=0xFFFF -> product=0xFFFE0001 (exercises carry via aluOfl).
REQ-038 sgn=1: opA=0xFFFD (-3), opB=5 -> 0xFFFFFFF1; opA=0x8000, opB=0x8000 -> 0x40000000.
REQ-039 start pulsed at cycles 5 and 10 of an operation -> ignored; exactly one done; product matches the first operands.
REQ-040 rst low at cycle 8 of an operation -> busy=0, product=0 immediately; no done; the next operation yields a correct result.
REQ-041 start held high for 40 cycles with operands 7x9 -> done pulses every 18 cycles; product=0x0000003F each time.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode, multiplier width and multiplier FSM state encoding
package alu_pkg;
  localparam int N = 16;
  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} mult_state_t;
  // 0x8000 maps onto itself, which is the correct unsigned magnitude
  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic s);
    return (s && v[N-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/alu_mult_seq_if.sv
// alu_mult_seq_if: multiply request/response bundle
interface alu_mult_seq_if;
  import alu_pkg::*;
  logic start, sgn, busy, done;
  logic [N-1:0] opA, opB;
  logic [2*N-1:0] product;
  modport master(output start, opA, opB, sgn, input busy, done, product);
  modport slave(input start, opA, opB, sgn, output busy, done, product);
endinterface

// File: rtl/mult_fsm.sv
// mult_fsm: IDLE/ITER/DONE sequencing and iteration count for the shift-add multiplier
module mult_fsm
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic accept,
  output logic iter,
  output logic last,
  output logic busy,
  output logic done
);
  mult_state_t state, state_nxt;
  logic [$clog2(N)-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= accept ? '0 : iter ? cnt + 1'b1 : cnt;
    end
  always_comb
    state_nxt = accept ? ITER : last ? DONE : iter ? ITER : IDLE;
  always_comb begin
    accept = state == IDLE && start;
    iter = state == ITER;
    last = iter && &cnt;
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: 16x16 sequential shift-add multiplier using an external ALU for every addition
module alu_mult_seq
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_mult_seq_if.slave  req,
  output logic [N-1:0]   aluA,
  output logic [N-1:0]   aluB,
  output logic [3:0]     aluOp,
  output logic           aluCin,
  output logic           aluInvA,
  output logic           aluInvB,
  output logic           aluSign,
  input  logic [N-1:0]   aluOut,
  input  logic           aluOfl,
  input  logic           aluZero,
  input  logic           aluNeg
);
  logic accept, iter, last, neg, unused_flags;
  logic [N-1:0] mcand, mplr, acc_hi;
  logic [2*N-1:0] nxt;
  mult_fsm u_fsm (
    .clk(clk), .rst(rst), .start(req.start), .accept(accept), .iter(iter),
    .last(last), .busy(req.busy), .done(req.done)
  );
  // carry-out of the add becomes the top bit of the shifted accumulator
  assign nxt = {aluOfl, aluOut, mplr[N-1:1]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mcand <= '0;
      mplr <= '0;
      acc_hi <= '0;
      neg <= 1'b0;
      req.product <= '0;
    end else if (accept) begin
      mcand <= mag(req.opA, req.sgn);
      mplr <= mag(req.opB, req.sgn);
      acc_hi <= '0;
      neg <= req.sgn & (req.opA[N-1] ^ req.opB[N-1]);
    end else if (iter) begin
      {acc_hi, mplr} <= nxt;
      if (last) req.product <= neg ? -nxt : nxt;
    end
  always_comb begin
    aluA = iter ? acc_hi : '0;
    aluB = iter && mplr[0] ? mcand : '0;
  end
  assign aluOp = ALU_OP_ADD;
  assign aluCin = 1'b0;
  assign aluInvA = 1'b0;
  assign aluInvB = 1'b0;
  assign aluSign = 1'b0;
  assign unused_flags = aluZero ^ aluNeg;
endmodule
